// File: rtl/pc_sequencer_if.sv
// Handshake, decode and LUT signals between the PC sequencer and the fetch/control side.
// master: the side driving Start/decode/LUT results; slave: the sequencer itself.
interface pc_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          Start;
  logic [D-1:0]  ProgBase;
  logic          Stall;
  logic          Halt;
  logic          BranchEn;
  logic          BranchCond;
  logic [4:0]    BranchIdx;
  logic [4:0]    lut_addr;
  logic [D-1:0]  lut_target;
  logic [D-1:0]  PC;
  logic          Fetch;
  logic          Taken;
  logic          Done;
  logic          Timeout;
  logic [CW-1:0] CycleCount;

  modport master (
    output Start, ProgBase, Stall, Halt, BranchEn, BranchCond, BranchIdx, lut_target,
    input  lut_addr, PC, Fetch, Taken, Done, Timeout, CycleCount
  );

  modport slave (
    input  Start, ProgBase, Stall, Halt, BranchEn, BranchCond, BranchIdx, lut_target,
    output lut_addr, PC, Fetch, Taken, Done, Timeout, CycleCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE run control, next-PC mux with LUT branch
// redirect, saturating RUN-cycle counter and watchdog.
module pc_sequencer #(
  parameter int            D          = 12,
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = 16'd4000
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] WD_LAST = MAX_CYCLES - 1'b1;

  state_t        state, state_n;
  logic [D-1:0]  pc, pc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          taken, taken_n;
  logic          timeout, timeout_n;
  logic          br_take;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      cnt     <= '0;
      taken   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      cnt     <= cnt_n;
      taken   <= taken_n;
      timeout <= timeout_n;
    end
  end

  assign br_take = bus.BranchEn & bus.BranchCond & (bus.BranchIdx != 5'd0);

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    cnt_n     = cnt;
    taken_n   = 1'b0;
    timeout_n = timeout;
    unique case (state)
      IDLE, DONE: begin
        if (bus.Start) begin
          state_n   = RUN;
          pc_n      = bus.ProgBase;
          cnt_n     = '0;
          timeout_n = 1'b0;
        end
      end
      RUN: begin
        cnt_n = (cnt == '1) ? cnt : cnt + 1'b1;
        // >= rather than == so a stall on the limit cycle cannot defeat the watchdog
        if (bus.Stall) begin
          pc_n = pc;
        end else if (bus.Halt) begin
          state_n = DONE;
        end else if (cnt >= WD_LAST) begin
          state_n   = DONE;
          timeout_n = 1'b1;
        end else if (br_take) begin
          pc_n    = bus.lut_target;
          taken_n = 1'b1;
        end else begin
          pc_n = pc + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.lut_addr   = (state == RUN) ? bus.BranchIdx : 5'd0;
  assign bus.PC         = pc;
  assign bus.Fetch      = (state == RUN);
  assign bus.Done       = (state == DONE);
  assign bus.Taken      = taken;
  assign bus.Timeout    = timeout;
  assign bus.CycleCount = cnt;

endmodule
